// File: rtl/cpu_pkg.sv
// Shared CPU package: instruction-memory geometry and loader FSM states.
// Reused by the loader, the instruction memory and the core.
package cpu_pkg;

    localparam int IMEM_DEPTH = 32;
    localparam int IMEM_AW    = 5;
    localparam int IMEM_DW    = 16;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        HI,
        LO,
        CHECK,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream instruction loader: count byte, N big-endian 16-bit words,
// XOR checksum byte. Writes each word to imem as soon as it is assembled.
module imem_loader
    import cpu_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW,
    parameter int DW    = IMEM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   words_loaded
);

    localparam int CW = AW + 1;

    loader_state_t state;
    loader_state_t state_nx;

    logic [CW-1:0] cnt;
    logic [CW-1:0] wl_q;
    logic [15:0]   word;
    logic [7:0]    csum;
    logic          we_q;

    logic take;
    logic idle_like;
    logic n_bad;
    logic last;

    assign busy      = (state == COUNT) || (state == HI) ||
                       (state == LO) || (state == CHECK);
    assign in_ready  = busy;
    assign take      = in_valid && in_ready;
    assign idle_like = (state == IDLE) || (state == DONE) || (state == ERR);
    assign n_bad     = (in_data == 8'd0) || (int'(in_data) > DEPTH);
    assign last      = (wl_q + CW'(1)) == cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE, ERR: if (start) state_nx = COUNT;
            COUNT:           if (take) state_nx = n_bad ? ERR : HI;
            HI:              if (take) state_nx = LO;
            LO:              if (take) state_nx = last ? CHECK : HI;
            CHECK:           if (take) state_nx = (in_data == csum) ? DONE : ERR;
            default:         state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            wl_q <= '0;
            word <= '0;
            csum <= '0;
            we_q <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (we_q) wl_q <= wl_q + CW'(1);
            if (take) begin
                case (state)
                    COUNT: cnt <= CW'(in_data);
                    HI: begin
                        word[15:8] <= in_data;
                        csum       <= csum ^ in_data;
                    end
                    LO: begin
                        word[7:0] <= in_data;
                        csum      <= csum ^ in_data;
                        we_q      <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (start && idle_like) begin
                wl_q <= '0;
                csum <= '0;
            end
        end
    end

    // A reset landing on the write cycle must suppress the pending pulse.
    assign we           = we_q && !rst;
    assign waddr        = wl_q[AW-1:0];
    assign wdata        = DW'(word);
    assign words_loaded = wl_q;
    assign done         = (state == DONE);
    assign err          = (state == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: vector table of short loads plus
// hand-written sequences for gaps, mid-load reset and start handling.
module tb_imem_loader;
    import cpu_pkg::*;

    localparam int AW = 5;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    imem_loader dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .we(we),
        .waddr(waddr),
        .wdata(wdata),
        .busy(busy),
        .done(done),
        .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];

    typedef struct {
        logic [47:0] bytes;
        int          nb;
        logic        exp_done;
        logic        exp_err;
        int          exp_words;
        int          nwr;
        logic [15:0] w0;
        logic [15:0] w1;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (we === 1'b1) begin
            wa_q.push_back(waddr);
            wd_q.push_back(wdata);
            chk("we_outside_load", {31'd0, busy}, 32'd1);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int   n;
        logic acc;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 40);
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_we"}, {31'd0, we}, 32'd0);
        chk({tag, "_waddr"}, 32'(waddr), 32'd0);
        chk({tag, "_wdata"}, 32'(wdata), 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic clear_writes();
        wa_q.delete();
        wd_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] bb;
        logic [7:0]  x;
        logic [7:0]  hb;
        logic [7:0]  lb;

        vecs[0] = '{48'h02_12_34_AB_CD_40, 6, 1'b1, 1'b0, 2, 2,
                    16'h1234, 16'hABCD};
        vecs[1] = '{48'h00_00_00_00_00_00, 1, 1'b0, 1'b1, 0, 0,
                    16'h0, 16'h0};
        vecs[2] = '{48'h21_00_00_00_00_00, 1, 1'b0, 1'b1, 0, 0,
                    16'h0, 16'h0};
        vecs[3] = '{48'h01_00_01_00_00_00, 4, 1'b0, 1'b1, 1, 1,
                    16'h0001, 16'h0};
        vecs[4] = '{48'h01_5A_A5_FF_00_00, 4, 1'b1, 1'b0, 1, 1,
                    16'h5AA5, 16'h0};

        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset_values("rst");
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            pulse_start();
            clear_writes();
            bb = vecs[v].bytes;
            for (int i = 0; i < vecs[v].nb; i++) begin
                send_byte(bb[47-8*i -: 8], 0);
            end
            in_valid = 1'b0;
            chk($sformatf("v%0d_done", v), {31'd0, done},
                {31'd0, vecs[v].exp_done});
            chk($sformatf("v%0d_err", v), {31'd0, err},
                {31'd0, vecs[v].exp_err});
            chk($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
            chk($sformatf("v%0d_words", v), 32'(words_loaded),
                32'(vecs[v].exp_words));
            chk($sformatf("v%0d_nwr", v), 32'(wa_q.size()),
                32'(vecs[v].nwr));
            if (vecs[v].nwr > 0 && wa_q.size() > 0) begin
                chk($sformatf("v%0d_a0", v), 32'(wa_q[0]), 32'd0);
                chk($sformatf("v%0d_d0", v), 32'(wd_q[0]), 32'(vecs[v].w0));
            end
            if (vecs[v].nwr > 1 && wa_q.size() > 1) begin
                chk($sformatf("v%0d_a1", v), 32'(wa_q[1]), 32'd1);
                chk($sformatf("v%0d_d1", v), 32'(wd_q[1]), 32'(vecs[v].w1));
            end
        end

        // full-depth load with random in_valid gaps
        pulse_start();
        clear_writes();
        x = 8'h00;
        send_byte(8'd32, $urandom_range(0, 2));
        for (int i = 0; i < 32; i++) begin
            hb = 8'(i);
            lb = 8'(i * 7 + 3);
            x = x ^ hb ^ lb;
            send_byte(hb, $urandom_range(0, 2));
            send_byte(lb, $urandom_range(0, 2));
        end
        send_byte(x, $urandom_range(0, 2));
        in_valid = 1'b0;
        chk("full_done", {31'd0, done}, 32'd1);
        chk("full_err", {31'd0, err}, 32'd0);
        chk("full_words", 32'(words_loaded), 32'd32);
        chk("full_nwr", 32'(wa_q.size()), 32'd32);
        for (int i = 0; i < 32 && i < wa_q.size(); i++) begin
            chk($sformatf("full_a%0d", i), 32'(wa_q[i]), 32'(i));
            chk($sformatf("full_d%0d", i), 32'(wd_q[i]),
                32'({8'(i), 8'(i * 7 + 3)}));
        end

        // reset on the cycle that would carry the third word's write
        pulse_start();
        clear_writes();
        send_byte(8'h04, 0);
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_we", {31'd0, we}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_values("rstmid");
        chk("rstmid_nwr", 32'(wa_q.size()), 32'd2);
        pulse_start();
        clear_writes();
        bb = vecs[0].bytes;
        for (int i = 0; i < 6; i++) send_byte(bb[47-8*i -: 8], 0);
        in_valid = 1'b0;
        chk("reload_done", {31'd0, done}, 32'd1);
        chk("reload_words", 32'(words_loaded), 32'd2);
        chk("reload_nwr", 32'(wa_q.size()), 32'd2);
        if (wd_q.size() > 1) begin
            chk("reload_d0", 32'(wd_q[0]), 32'h1234);
            chk("reload_d1", 32'(wd_q[1]), 32'hABCD);
        end

        // start in HI is ignored, start in DONE begins a new load
        pulse_start();
        clear_writes();
        send_byte(8'h02, 0);
        in_valid = 1'b0;
        pulse_start();
        chk("hi_start_busy", {31'd0, busy}, 32'd1);
        chk("hi_start_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 1; i < 6; i++) send_byte(bb[47-8*i -: 8], 0);
        in_valid = 1'b0;
        chk("hi_start_done", {31'd0, done}, 32'd1);
        chk("hi_start_nwr", 32'(wa_q.size()), 32'd2);
        if (wd_q.size() > 1) begin
            chk("hi_start_d0", 32'(wd_q[0]), 32'h1234);
            chk("hi_start_d1", 32'(wd_q[1]), 32'hABCD);
        end
        pulse_start();
        chk("done_start_done", {31'd0, done}, 32'd0);
        chk("done_start_busy", {31'd0, busy}, 32'd1);
        chk("done_start_words", 32'(words_loaded), 32'd0);
        clear_writes();
        bb = vecs[4].bytes;
        for (int i = 0; i < 4; i++) send_byte(bb[47-8*i -: 8], 0);
        in_valid = 1'b0;
        chk("second_done", {31'd0, done}, 32'd1);
        chk("second_words", 32'(words_loaded), 32'd1);
        chk("second_nwr", 32'(wa_q.size()), 32'd1);
        if (wd_q.size() > 0) chk("second_d0", 32'(wd_q[0]), 32'h5AA5);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning instruction-memory word count.
REQ-002 SHALL have parameter AW, default 5, meaning write-address width.
REQ-003 SHALL have parameter DW, default 16, meaning instruction word width.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  single-cycle load request.
REQ-007 SHALL have port in_valid  input  1  byte-stream valid.
REQ-008 SHALL have port in_data  input  8  byte-stream data.
REQ-009 SHALL have port in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-010 SHALL have port we  output  1  instruction-memory write enable, one-cycle pulse.
REQ-011 SHALL have port waddr  output  AW  write address.
REQ-012 SHALL have port wdata  output  DW  write data.
REQ-013 SHALL have port busy  output  1  load in progress.
REQ-014 SHALL have port done  output  1  load finished, checksum good (level).
REQ-015 SHALL have port err  output  1  load aborted or checksum bad (level).
REQ-016 SHALL have port words_loaded  output  AW+1  count of words written this load.

Function
REQ-017 SHALL implement FSM states IDLE, COUNT, HI, LO, CHECK, DONE, ERR.
REQ-018 SHALL leave IDLE, DONE or ERR for COUNT on start; start in COUNT/HI/LO/CHECK is ignored.
REQ-019 SHALL clear done, err, words_loaded and the checksum accumulator on the same edge start is taken.
REQ-020 SHALL drive in_ready high exactly in COUNT, HI, LO, CHECK; in_ready is a function of state only.
REQ-021 SHALL, in COUNT, accept byte N; N in 1..DEPTH -> HI; N = 0 or N > DEPTH -> ERR, no writes.
REQ-022 SHALL, in HI, latch accepted byte as wdata[15:8] and go to LO.
REQ-023 SHALL, in LO, latch accepted byte as wdata[7:0]; pulse we on the next cycle with waddr = words_loaded (pre-increment) and the assembled word.
REQ-024 SHALL increment words_loaded on the cycle we is high; go to HI if words remain, else CHECK.
REQ-025 SHALL keep a running XOR of all 2N data bytes (count byte excluded).
REQ-026 SHALL, in CHECK, compare the accepted byte to the XOR; equal -> DONE, else -> ERR.
REQ-027 SHALL hold done high in DONE and err high in ERR until next start or rst.
REQ-028 SHALL hold busy high in COUNT, HI, LO, CHECK; low otherwise.
REQ-029 SHALL, while in_valid is low, hold state and all data registers; no timeout.
REQ-030 SHALL accept one byte per cycle back-to-back with no bubbles; a full load of N words takes 2N+2 accepted bytes.
REQ-031 SHALL never assert we outside a load, and at most N times per load; waddr never exceeds N-1.
REQ-032 SHALL NOT roll back words already written when err is raised; err tells the system to hold the CPU in reset.

Reset
REQ-033 SHALL, on rst, go to IDLE with in_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, err=0, words_loaded=0, XOR=0.
REQ-034 SHALL give rst priority over start and in_valid; a reset mid-load aborts it with no further we pulse, including one pending from LO.

Structure
REQ-035 SHALL take the state enum type and DEPTH/AW/DW defaults from shared package cpu_pkg, reused by imem and the CPU.
REQ-036 SHALL be one flat module; no sub-module, single FSM plus byte-assembly datapath.

Verification
REQ-037 SHALL test N=2, bytes 12 34 AB CD, checksum 12^34^AB^CD=40 -> we at addr0=0x1234, addr1=0xABCD, done=1, words_loaded=2.
REQ-038 SHALL test N=0 and N=33 -> err=1 next cycle, no we pulses, busy=0.
REQ-039 SHALL test N=1, bytes 00 01, checksum 00 -> one write addr0=0x0001, then err=1, done=0.
REQ-040 SHALL test a full N=32 load with random gaps in in_valid -> 32 writes, addresses 0..31 in order, done=1, words_loaded=32.
REQ-041 SHALL test rst asserted the cycle after the LO byte of word 3 -> no we that cycle, all outputs at reset values, next start reloads cleanly.
REQ-042 SHALL test start pulsed during HI -> ignored; start pulsed in DONE -> done drops, new load begins.
